// File: rtl/ss2m_gen_pkg.sv
// ss2m_gen_pkg
// Shared definitions for the S2MM stream generator and anything that has to
// reproduce its data patterns (e.g. a read-side checker).
//   - mode_e     : pattern select encodings
//   - state_e    : frame FSM state encoding
//   - LFSR_TAPS  : tap mask for x^32 + x^22 + x^2 + x + 1 (shift-left form)
//   - lfsr_step  : one Fibonacci LFSR step
//   - lfsr_seed  : seed conditioning (the all-zero state would lock up)
package ss2m_gen_pkg;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_RAMP  = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  // Bits 31, 21, 1 and 0 feed the XOR; the new bit shifts in at bit 0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {v[30:0], ^(v & LFSR_TAPS)};
  endfunction

  function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/ss2m_pattern_unit.sv
// ss2m_pattern_unit
// Produces one DW-bit data word of the selected test pattern for beat index
// `beat`. Everything is combinational except the LFSR state register.
// Ports:
//   axis_clk, axis_reset : clock and synchronous active-high reset
//   mode    [1:0]        : pattern select (mode_e encoding)
//   seed    [31:0]       : pattern seed (must be stable while the frame runs)
//   beat    [LEN_W-1:0]  : beat index within the frame
//   load                 : load LFSR from the conditioned seed
//   advance              : step the LFSR once (one per handshake)
//   data    [DW-1:0]     : pattern word for the current beat
module ss2m_pattern_unit
  import ss2m_gen_pkg::*;
#(
  parameter int DW    = 64,
  parameter int LEN_W = 26
) (
  input  logic             axis_clk,
  input  logic             axis_reset,
  input  logic [1:0]       mode,
  input  logic [31:0]      seed,
  input  logic [LEN_W-1:0] beat,
  input  logic             load,
  input  logic             advance,
  output logic [DW-1:0]    data
);

  localparam int BPB = DW / 8;

  logic [31:0]   lfsr_reg;
  logic [31:0]   lfsr_next;
  logic [7:0]    ramp_base;
  logic [DW-1:0] cnt_data;
  logic [DW-1:0] ramp_data;
  logic [DW-1:0] lfsr_data;
  logic [DW-1:0] const_data;

  // Load wins over advance: a new frame always restarts from the seed.
  always_comb begin
    lfsr_next = lfsr_reg;
    if (load) begin
      lfsr_next = lfsr_seed(seed);
    end else if (advance) begin
      lfsr_next = lfsr_step(lfsr_reg);
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      lfsr_reg <= 32'd0;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  // Only the low 8 bits of n*BPB matter for a mod-256 ramp.
  assign ramp_base = seed[7:0] + beat[7:0] * 8'(BPB);

  for (genvar gi = 0; gi < BPB; gi++) begin : g_ramp
    assign ramp_data[8*gi +: 8] = ramp_base + 8'(gi);
  end

  for (genvar gi = 0; gi < DW; gi++) begin : g_bits
    // Beat counter: zero-extend or truncate the index to DW.
    if (gi < LEN_W) begin : g_cnt
      assign cnt_data[gi] = beat[gi];
    end else begin : g_cnt_pad
      assign cnt_data[gi] = 1'b0;
    end
    // 32-bit values replicated across DW (truncated when DW < 32).
    assign lfsr_data[gi]  = lfsr_reg[gi % 32];
    assign const_data[gi] = seed[gi % 32];
  end

  always_comb begin
    data = cnt_data;
    case (mode)
      MODE_CNT:   data = cnt_data;
      MODE_RAMP:  data = ramp_data;
      MODE_LFSR:  data = lfsr_data;
      MODE_CONST: data = const_data;
      default:    data = cnt_data;
    endcase
  end

endmodule

// File: rtl/ss2m_stream_generator.sv
// ss2m_stream_generator
// AXI4-Stream test-pattern source for the S2MM side of the DMA write path.
// Each accepted start emits one frame of `length` bytes in the selected
// pattern; the final beat may be partial and is marked through tkeep.
// Ports:
//   axis_clk, axis_reset   : clock and synchronous active-high reset
//   start                  : one-cycle command pulse (ignored while not IDLE)
//   length [LEN_W-1:0]     : frame length in bytes (sampled on start)
//   mode   [1:0]           : pattern select (sampled on start)
//   seed   [31:0]          : pattern seed (sampled on start)
//   busy                   : frame in progress
//   done                   : one-cycle pulse at frame end
//   m_axis_tdata/tkeep/tvalid/tlast/tready : AXI4-Stream master
module ss2m_stream_generator
  import ss2m_gen_pkg::*;
#(
  parameter int DW    = 64,
  parameter int LEN_W = 26
) (
  input  logic              axis_clk,
  input  logic              axis_reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  length,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     m_axis_tdata,
  output logic [DW/8-1:0]   m_axis_tkeep,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready
);

  localparam int BPB = DW / 8;

  state_e           state_reg, state_next;
  logic [LEN_W-1:0] beat_reg, beat_next;
  logic [LEN_W-1:0] last_idx_reg, last_idx_next;
  logic [BPB-1:0]   last_keep_reg, last_keep_next;
  logic [1:0]       mode_reg, mode_next;
  logic [31:0]      seed_reg, seed_next;

  logic             accept;
  logic             handshake;
  logic             is_last;
  logic [LEN_W-1:0] len_rem;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W-1:0] nbeats_calc;
  logic [BPB-1:0]   keep_calc;
  logic [31:0]      pat_seed;
  logic [DW-1:0]    pat_data;

  assign accept    = (state_reg == ST_IDLE) && start;
  assign handshake = (state_reg == ST_RUN) && m_axis_tready;
  assign is_last   = (beat_reg == last_idx_reg);

  // nbeats = floor(len/BPB) + (rem != 0); avoids the overflow that
  // (len + BPB - 1) / BPB would hit near the top of the length range.
  assign len_rem     = length % LEN_W'(BPB);
  assign len_full    = length / LEN_W'(BPB);
  assign nbeats_calc = len_full + {{(LEN_W-1){1'b0}}, (len_rem != '0)};

  for (genvar gi = 0; gi < BPB; gi++) begin : g_keep
    assign keep_calc[gi] = (len_rem == '0) || (len_rem > LEN_W'(gi));
  end

  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    last_idx_next  = last_idx_reg;
    last_keep_next = last_keep_reg;
    mode_next      = mode_reg;
    seed_next      = seed_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          beat_next      = '0;
          last_idx_next  = nbeats_calc - LEN_W'(1);
          last_keep_next = keep_calc;
          mode_next      = mode;
          seed_next      = seed;
          state_next     = (length != '0) ? ST_RUN : ST_FIN;
        end
      end
      ST_RUN: begin
        if (m_axis_tready) begin
          if (is_last) begin
            state_next = ST_FIN;
          end else begin
            beat_next = beat_reg + LEN_W'(1);
          end
        end
      end
      ST_FIN: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_reset) begin
      state_reg     <= ST_IDLE;
      beat_reg      <= '0;
      last_idx_reg  <= '0;
      last_keep_reg <= '0;
      mode_reg      <= '0;
      seed_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      last_idx_reg  <= last_idx_next;
      last_keep_reg <= last_keep_next;
      mode_reg      <= mode_next;
      seed_reg      <= seed_next;
    end
  end

  // The LFSR loads on the accepting edge, so it needs the live seed then;
  // during the frame the captured copy keeps ramp/const data stable.
  assign pat_seed = accept ? seed : seed_reg;

  ss2m_pattern_unit #(
    .DW    (DW),
    .LEN_W (LEN_W)
  ) u_pattern (
    .axis_clk   (axis_clk),
    .axis_reset (axis_reset),
    .mode       (mode_reg),
    .seed       (pat_seed),
    .beat       (beat_reg),
    .load       (accept),
    .advance    (handshake),
    .data       (pat_data)
  );

  // All outputs decode registered state only, so tvalid never depends on
  // tready and every beat field holds while the sink stalls.
  assign m_axis_tvalid = (state_reg == ST_RUN);
  assign busy          = (state_reg == ST_RUN);
  assign done          = (state_reg == ST_FIN);
  assign m_axis_tlast  = m_axis_tvalid && is_last;
  assign m_axis_tkeep  = !m_axis_tvalid ? '0 : (is_last ? last_keep_reg : '1);
  assign m_axis_tdata  = m_axis_tvalid ? pat_data : '0;

endmodule

// File: tb/tb_ss2m_stream_generator.sv
module tb_ss2m_stream_generator;

  localparam int DW    = 64;
  localparam int LEN_W = 26;

  logic             axis_clk = 1'b0;
  logic             axis_reset;
  logic             start;
  logic [LEN_W-1:0] length;
  logic [1:0]       mode;
  logic [31:0]      seed;
  logic             busy;
  logic             done;
  logic [DW-1:0]    m_axis_tdata;
  logic [DW/8-1:0]  m_axis_tkeep;
  logic             m_axis_tvalid;
  logic             m_axis_tlast;
  logic             m_axis_tready;

  int checks = 0;
  int errors = 0;

  always #5 axis_clk = ~axis_clk;

  ss2m_stream_generator #(.DW(DW), .LEN_W(LEN_W)) dut (
    .axis_clk      (axis_clk),
    .axis_reset    (axis_reset),
    .start         (start),
    .length        (length),
    .mode          (mode),
    .seed          (seed),
    .busy          (busy),
    .done          (done),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Outputs are observed 1 time unit after the active edge.
  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  // Reference LFSR: x^32 + x^22 + x^2 + x + 1, new bit enters at the bottom.
  function automatic logic [31:0] lfsr_ref(input logic [31:0] v);
    logic fb;
    fb = v[31] ^ v[21] ^ v[1] ^ v[0];
    return {v[30:0], fb};
  endfunction

  function automatic bit pick_ready(input int kind, input int cyc);
    case (kind)
      0:       return 1'b1;
      1:       return (cyc % 3) == 0;       // 1,0,0,1,0,0,...
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Runs one frame and compares every cycle against a model built up front.
  // poke=1 additionally fires start during RUN and during the done cycle.
  task automatic run_frame(input int len, input int md, input logic [31:0] sd,
                           input int rdy_kind, input bit poke);
    logic [63:0] ed[$];
    logic [7:0]  ek[$];
    logic [63:0] w;
    logic [31:0] v;
    int nb, n, cyc;
    bit poked;
    nb = (len + 7) / 8;
    v  = (sd == 32'd0) ? 32'd1 : sd;
    for (int b = 0; b < nb; b++) begin
      case (md)
        0: w = 64'(b);
        1: for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'((int'(sd[7:0]) + b*8 + k) % 256);
        2: begin w = {v, v}; v = lfsr_ref(v); end
        default: w = {sd, sd};
      endcase
      ed.push_back(w);
      ek.push_back((b == nb-1 && (len % 8) != 0) ? 8'((1 << (len % 8)) - 1) : 8'hFF);
    end
    $display("frame len=%0d mode=%0d seed=%h ready_kind=%0d beats=%0d", len, md, sd, rdy_kind, nb);

    start = 1'b1; length = LEN_W'(len); mode = 2'(md); seed = sd;
    m_axis_tready = 1'b1;
    tick();
    start = 1'b0;
    // Scramble command inputs to show they were captured on the start edge.
    length = LEN_W'($urandom); mode = 2'($urandom); seed = $urandom;

    if (nb == 0) begin
      check("len0_done", 64'(done), 64'd1);
      check("len0_busy", 64'(busy), 64'd0);
      check("len0_tvalid", 64'(m_axis_tvalid), 64'd0);
      tick();
      check("len0_done_clr", 64'(done), 64'd0);
      return;
    end

    n = 0; cyc = 0; poked = 0;
    while (n < nb && cyc < 400) begin
      check("tvalid", 64'(m_axis_tvalid), 64'd1);
      check("busy", 64'(busy), 64'd1);
      check("done_mid", 64'(done), 64'd0);
      check($sformatf("tdata[%0d]", n), m_axis_tdata, ed[n]);
      check($sformatf("tkeep[%0d]", n), 64'(m_axis_tkeep), 64'(ek[n]));
      check($sformatf("tlast[%0d]", n), 64'(m_axis_tlast), 64'(n == nb-1));
      m_axis_tready = pick_ready(rdy_kind, cyc);
      if (poke && !poked && n == 1) begin
        start = 1'b1; length = LEN_W'(5); poked = 1;
      end
      tick();
      start = 1'b0;
      if (m_axis_tready) n++;
      cyc++;
    end
    check("frame_timeout", 64'(n), 64'(nb));

    check("end_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("end_busy", 64'(busy), 64'd0);
    check("end_done", 64'(done), 64'd1);
    check("end_tkeep", 64'(m_axis_tkeep), 64'd0);
    if (poke) begin
      start = 1'b1; length = LEN_W'(5);
    end
    tick();
    start = 1'b0;
    check("post_done", 64'(done), 64'd0);
    check("post_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    axis_reset = 1'b1; start = 1'b0; length = '0; mode = '0; seed = '0;
    m_axis_tready = 1'b0;
    tick(); tick();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    axis_reset = 1'b0;
    tick();

    run_frame(32, 0, 32'h0, 0, 0);
    run_frame(13, 3, 32'hA5A5_A5A5, 0, 0);
    run_frame(16, 1, 32'h10, 0, 0);
    run_frame(40, 2, 32'h0, 1, 0);
    run_frame(0, 0, 32'h0, 0, 0);
    run_frame(24, 3, 32'h1234_5678, 2, 1);

    // Mid-frame reset after the beat-2 handshake of a 10-beat frame.
    $display("frame len=80 mode=2 seed=deadbeef reset after beat 2");
    start = 1'b1; length = LEN_W'(80); mode = 2'd2; seed = 32'hDEAD_BEEF;
    m_axis_tready = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_tvalid", 64'(m_axis_tvalid), 64'd1);
    axis_reset = 1'b1;
    tick();
    axis_reset = 1'b0;
    check("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_tdata", m_axis_tdata, 64'd0);
    tick();
    check("midrst_done2", 64'(done), 64'd0);
    check("midrst_tvalid2", 64'(m_axis_tvalid), 64'd0);
    run_frame(80, 2, 32'hDEAD_BEEF, 0, 0);

    for (int i = 0; i < 12; i++) begin
      run_frame($urandom_range(0, 40), $urandom_range(0, 3), $urandom, 2, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
